// File: rtl/dmem_responder.sv
// Word-addressed data memory that answers CPU requests after a fixed number of wait states.
// One transaction in flight at a time; misaligned or out-of-range requests return err.
module dmem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MEM_SIZE    = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [WIDTH-1:0]      addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    be,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ack,
  output logic                  err,
  output logic                  busy,
  input  logic [MEM_SIZE-1:0]   dbg_addr,
  output logic [WIDTH-1:0]      dbg_data
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << MEM_SIZE;
  localparam int unsigned CW     = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_we;
  logic [WIDTH-1:0]    r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic [NBYTES-1:0]   r_be;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [WIDTH-1:0]    r_rdata;
  logic                r_ack;
  logic                r_err;
  logic                r_busy;

  logic                w_we;
  logic [WIDTH-1:0]    w_addr;
  logic [WIDTH-1:0]    w_wdata;
  logic [NBYTES-1:0]   w_be;
  logic [MEM_SIZE-1:0] w_idx;
  logic                w_err;
  logic                w_respond;

  // With zero wait states the response is built straight from the request inputs.
  always_comb begin
    w_we      = r_we;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_be      = r_be;
    if (r_state == S_IDLE) begin
      w_we    = we;
      w_addr  = addr;
      w_wdata = wdata;
      w_be    = be;
    end
    w_idx     = w_addr[MEM_SIZE+1:2];
    w_err     = (w_addr[1:0] != 2'b00) || ((w_addr >> (MEM_SIZE + 2)) != '0);
    w_respond = ((r_state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                ((r_state == S_WAIT) && (r_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[MEM_SIZE'(i)] <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Response and memory update happen on the edge that enters RESP.
      if (w_respond) begin
        r_ack <= 1'b1;
        r_err <= w_err;
        if (!w_err) begin
          if (w_we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
              if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
          end else begin
            r_rdata <= r_mem[w_idx];
          end
        end
      end
    end
  end

  assign rdata    = r_rdata;
  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = r_busy;
  assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a memory-array model predicts each response,
// a negedge monitor pops and compares whenever ack is seen.
module tb_dmem_responder;
  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata, rdata, dbg_data;
  logic [3:0]  be;
  logic        ack, err, busy;
  logic [4:0]  dbg_addr;

  logic        z_req, z_we;
  logic [31:0] z_addr, z_wdata, z_rdata, z_dbg_data;
  logic [3:0]  z_be;
  logic        z_ack, z_err, z_busy;
  logic [4:0]  z_dbg_addr;

  dmem_responder #(.WIDTH(32), .MEM_SIZE(5), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  dmem_responder #(.WIDTH(32), .MEM_SIZE(5), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata), .be(z_be),
    .rdata(z_rdata), .ack(z_ack), .err(z_err), .busy(z_busy), .dbg_addr(z_dbg_addr),
    .dbg_data(z_dbg_data));

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m[32];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference: a request either errors, reads a whole word, or merges enabled bytes.
  task automatic model_issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, input int acc);
    exp_t e;
    logic bad;
    int   idx;
    bad   = (a[1:0] != 2'b00) || (a[31:7] != 25'd0);
    idx   = int'(a[6:2]);
    e.err = bad;
    e.rdata = 32'd0;
    e.cyc = acc + int'(WC);
    if (!bad) begin
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) m[idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rdata = m[idx];
      end
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_ack: got ack=1 err=%b rdata=%h expected no ack (cycle %0d)",
                   err, rdata, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_err", 32'(err), 32'(e.err));
          chk("ack_rdata", rdata, e.rdata);
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("idle_err_rdata", {rdata[31:1], rdata[0] | err}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL wait_idle: got busy=%b expected 0 within 50 cycles", busy);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL drain: got %0d pending responses expected 0", q.size());
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    wait_idle();
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    model_issue(w, a, d, b, cyc + 1);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
  endtask

  task automatic dbg_chk(input string nm, input int idx);
    dbg_addr = 5'(idx);
    #1;
    chk(nm, dbg_data, m[idx]);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [4:0]  ix;
    int          acc;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; dbg_addr = '0;
    z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0; z_dbg_addr = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    dbg_chk("reset_dbg0", 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Full-word write then read back.
    issue(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    drain();

    // Single-byte merge.
    issue(1'b1, 32'hC, 32'h11223344, 4'hF);
    issue(1'b1, 32'hC, 32'h000000AA, 4'h1);
    issue(1'b0, 32'hC, 32'h0, 4'h0);
    drain();

    // Misaligned and out-of-range accesses, including a write that would alias word 0.
    issue(1'b0, 32'h6, 32'h0, 4'hF);
    issue(1'b0, 32'h80, 32'h0, 4'hF);
    issue(1'b1, 32'h80, 32'h55555555, 4'hF);
    drain();
    dbg_chk("dbg_idx0_no_alias", 0);
    dbg_chk("dbg_idx2", 2);
    dbg_chk("dbg_idx3", 3);

    // Zero byte-enable write leaves the word alone.
    issue(1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    drain();

    // req held high: accepted every WC+2 cycles only.
    wait_idle();
    req = 1'b1; we = 1'b0; addr = 32'hC; wdata = 32'h0; be = 4'hF;
    acc = cyc + 1;
    for (int k = 0; k < 3; k++) model_issue(1'b0, 32'hC, 32'h0, 4'hF, acc + k * int'(WC + 2));
    repeat (3 * (WC + 2)) @(negedge clk);
    req = 1'b0;
    drain();

    // Reset during the wait state of a write aborts it; req alongside rst is ignored.
    wait_idle();
    req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'hCAFEF00D; be = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    dbg_chk("abort_dbg_idx1", 1);
    dbg_chk("abort_dbg_idx2_cleared", 2);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      ix = 5'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    a = {25'd0, ix, 2'b00};
        2:       a = {25'd0, ix, 2'($urandom_range(1, 3))};
        default: a = {25'd0, ix, 2'b00} | (32'd1 << $urandom_range(7, 31));
      endcase
      issue(1'($urandom), a, $urandom, 4'($urandom));
    end
    drain();
    for (int i = 0; i < 32; i++) dbg_chk("rand_dbg_sweep", i);

    // Zero wait states: ack in the cycle right after acceptance.
    z_req = 1'b1; z_we = 1'b1; z_addr = 32'h10; z_wdata = 32'h0BADF00D; z_be = 4'hF;
    @(negedge clk);
    z_req = 1'b0; z_wdata = 32'h0;
    chk("w0_write_ack", 32'(z_ack), 32'd1);
    chk("w0_write_err", 32'(z_err), 32'd0);
    chk("w0_write_rdata", z_rdata, 32'd0);
    chk("w0_write_busy", 32'(z_busy), 32'd1);
    @(negedge clk);
    chk("w0_after_ack", 32'(z_ack), 32'd0);
    chk("w0_after_busy", 32'(z_busy), 32'd0);
    z_req = 1'b1; z_we = 1'b0; z_addr = 32'h10;
    @(negedge clk);
    z_req = 1'b0;
    chk("w0_read_ack", 32'(z_ack), 32'd1);
    chk("w0_read_rdata", z_rdata, 32'h0BADF00D);
    z_dbg_addr = 5'd4;
    #1;
    chk("w0_dbg_idx4", z_dbg_data, 32'h0BADF00D);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter MEM_SIZE, default 5, log2 of the word count (32 words).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (range 0..15).
REQ-004 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  request strobe from CPU
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  WIDTH  byte address
- wdata  input  WIDTH  write data
- be  input  WIDTH/8  byte enables, bit i = byte i
- rdata  output  WIDTH  read data, valid while ack = 1
- ack  output  1  one-cycle response strobe
- err  output  1  error flag, valid while ack = 1
- busy  output  1  high from acceptance through the ack cycle
- dbg_addr  input  MEM_SIZE  debug word index
- dbg_data  output  WIDTH  combinational read of mem[dbg_addr]

Function
REQ-005 SHALL contain 2^MEM_SIZE words of WIDTH bits, indexed by addr[MEM_SIZE+1:2].
REQ-006 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-007 In IDLE with req = 1, SHALL capture we, addr, wdata and be, and assert busy from the next cycle.
- Goes to WAIT if WAIT_CYCLES > 0.
- Goes to RESP if WAIT_CYCLES = 0.
REQ-008 In WAIT, SHALL decrement a wait counter loaded with WAIT_CYCLES-1, and go to RESP after it reaches 0 (exactly WAIT_CYCLES cycles spent in WAIT).
REQ-009 In RESP, SHALL assert ack for exactly one cycle, then return to IDLE.
REQ-010 Latency: for req accepted at edge N, ack SHALL be high during cycle N+1+WAIT_CYCLES.
REQ-011 req SHALL be ignored while busy = 1, including the RESP cycle; earliest next acceptance is the cycle after ack.
REQ-012 A request SHALL be an error if either condition holds:
- addr[1:0] != 0
- addr[WIDTH-1:MEM_SIZE+2] != 0
REQ-013 An error request SHALL produce the response ack = 1, err = 1, rdata = 0, with no memory update.
REQ-014 A valid read SHALL return the full word mem[index] on rdata with err = 0.
REQ-015 A valid write SHALL update only the bytes with be[i] = 1, at the RESP edge, and SHALL drive rdata = 0 with err = 0.
REQ-016 A write with be = 0 SHALL ack normally and leave memory unchanged.
REQ-017 Outside the ack cycle, ack = 0, err = 0 and rdata = 0.
REQ-018 dbg_data SHALL reflect writes from the cycle after the write's RESP edge.
REQ-019 Address index wrap is not permitted: out-of-range addresses are errors per REQ-012 and SHALL NOT alias.

Reset
REQ-020 When rst = 1 at a rising edge, the block SHALL return to:
- FSM state IDLE, wait counter 0
- ack = 0, err = 0, busy = 0, rdata = 0
- all memory words 0
REQ-021 Reset mid-transaction SHALL abort the transaction: no ack and no memory write.
REQ-022 req asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-023 The bench SHALL cover these directed scenarios (all with WAIT_CYCLES = 2 unless stated):
- Write 0xDEADBEEF to addr 0x8 with be = 0xF, then read addr 0x8 -> ack 3 cycles after each acceptance, rdata = 0xDEADBEEF, err = 0.
- Word at 0xC = 0x11223344; write 0x000000AA with be = 0x1 -> read returns 0x112233AA.
- Read addr 0x6 (misaligned), then addr 0x80 (out of range) -> ack with err = 1, rdata = 0; memory unchanged via dbg_data.
- req held high continuously -> accepted only in IDLE; one ack per 4 cycles; no double capture.
- rst asserted in the WAIT cycle of a write to 0x4 -> no ack; dbg_data at index 1 reads 0.
- WAIT_CYCLES = 0, read accepted at edge N -> ack in cycle N+1.
